// File: rtl/vis_packetiser.sv
// rtl/vis_packetiser.sv - packs complex visibility words into byte beats with optional per-frame header
// Header bytes 5A, ACCUM/8, seq lo, seq hi; word bytes imvis LSB-first then revis LSB-first.
module vis_packetiser #(
  parameter int ACCUM    = 32,
  parameter int MBYTES   = 1,
  parameter int HEADER   = 1,
  parameter int SEQ_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [ACCUM-1:0]      s_revis,
  input  logic [ACCUM-1:0]      s_imvis,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [MBYTES-1:0]     m_tkeep,
  output logic                  m_tlast,
  output logic [8*MBYTES-1:0]   m_tdata,
  output logic [SEQ_BITS-1:0]   frame_count_o,
  output logic                  busy_o
);

  localparam int WBEATS = (2 * ACCUM / 8) / MBYTES;
  localparam int HBEATS = 4 / MBYTES;
  localparam int SW     = (2 * ACCUM > 32) ? 2 * ACCUM : 32;
  localparam int DW     = 8 * MBYTES;
  localparam int BW     = 5;

  typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;

  state_t              state_q, state_d;
  logic                in_frame_q, in_frame_d;
  logic [SW-1:0]       sh_q, sh_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                last_q, last_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                m_tlast_q, m_tlast_d;
  logic [SEQ_BITS-1:0] frame_count_q, frame_count_d;

  logic        hdr_en;
  logic        accept;
  logic        handshake;
  logic        word_end;
  logic        head_end;
  logic [15:0] seq16;

  assign hdr_en    = (HEADER != 0);
  assign handshake = m_tvalid_q && m_tready;
  assign word_end  = (beat_q == BW'(WBEATS - 1));
  assign head_end  = (beat_q == BW'(HBEATS - 1));
  assign seq16     = 16'(frame_count_q);

  // s_tready is a pure function of state, beat index and m_tready
  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      IDLE:    s_tready = !(hdr_en && !in_frame_q);
      HEAD:    s_tready = m_tready && head_end;
      DATA:    s_tready = m_tready && word_end && !(last_q && hdr_en);
      default: s_tready = 1'b0;
    endcase
    if (reset) s_tready = 1'b0;
  end

  assign accept = s_tvalid && s_tready;

  always_comb begin
    state_d       = state_q;
    in_frame_d    = in_frame_q;
    sh_d          = sh_q;
    beat_d        = beat_q;
    last_d        = last_q;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (!accept && hdr_en && !in_frame_q && s_tvalid) begin
          state_d = HEAD;
          sh_d    = SW'({seq16, 8'(ACCUM / 8), 8'h5A});
          beat_d  = '0;
        end
      end
      HEAD: begin
        if (handshake) begin
          if (head_end) begin
            state_d    = IDLE;
            in_frame_d = 1'b1;
          end else begin
            sh_d   = sh_q >> DW;
            beat_d = beat_q + BW'(1);
          end
        end
      end
      DATA: begin
        if (handshake) begin
          if (word_end) begin
            state_d = IDLE;
            if (last_q) begin
              frame_count_d = frame_count_q + SEQ_BITS'(1);
              in_frame_d    = 1'b0;
            end
          end else begin
            sh_d   = sh_q >> DW;
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // an accepted word always wins: load it and go straight to DATA without a bubble
    if (accept) begin
      state_d    = DATA;
      in_frame_d = 1'b1;
      sh_d       = SW'({s_revis, s_imvis});
      beat_d     = '0;
      last_d     = s_tlast;
    end
    m_tvalid_d = (state_d != IDLE);
    m_tlast_d  = (state_d == DATA) && last_d && (beat_d == BW'(WBEATS - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      in_frame_q    <= 1'b0;
      sh_q          <= '0;
      beat_q        <= '0;
      last_q        <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      in_frame_q    <= in_frame_d;
      sh_q          <= sh_d;
      beat_q        <= beat_d;
      last_q        <= last_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_tvalid      = m_tvalid_q;
  assign m_tlast       = m_tlast_q;
  assign m_tdata       = sh_q[DW-1:0];
  assign m_tkeep       = {MBYTES{m_tvalid_q}};
  assign frame_count_o = frame_count_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_vis_packetiser.sv
// tb/tb_vis_packetiser.sv - directed self-checking bench for vis_packetiser
// Three instances: defaults, HEADER=0/MBYTES=4, and ACCUM=8/MBYTES=2/SEQ_BITS=4 for sequence wrap.
module tb_vis_packetiser;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // defaults instance
  logic        a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast, a_busy;
  logic [31:0] a_revis, a_imvis;
  logic [0:0]  a_m_tkeep;
  logic [7:0]  a_m_tdata;
  logic [15:0] a_count;

  vis_packetiser u_a (
    .clock(clock), .reset(reset),
    .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tlast(a_s_tlast),
    .s_revis(a_revis), .s_imvis(a_imvis),
    .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tkeep(a_m_tkeep),
    .m_tlast(a_m_tlast), .m_tdata(a_m_tdata),
    .frame_count_o(a_count), .busy_o(a_busy)
  );

  // raw words, 4 bytes per beat
  logic        b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast, b_busy;
  logic [31:0] b_revis, b_imvis, b_m_tdata;
  logic [3:0]  b_m_tkeep;
  logic [15:0] b_count;

  vis_packetiser #(.ACCUM(32), .MBYTES(4), .HEADER(0), .SEQ_BITS(16)) u_b (
    .clock(clock), .reset(reset),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tlast(b_s_tlast),
    .s_revis(b_revis), .s_imvis(b_imvis),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tkeep(b_m_tkeep),
    .m_tlast(b_m_tlast), .m_tdata(b_m_tdata),
    .frame_count_o(b_count), .busy_o(b_busy)
  );

  // narrow sequence counter so wrap is reachable quickly
  logic        c_s_tvalid, c_s_tready, c_s_tlast, c_m_tvalid, c_m_tready, c_m_tlast, c_busy;
  logic [7:0]  c_revis, c_imvis;
  logic [15:0] c_m_tdata;
  logic [1:0]  c_m_tkeep;
  logic [3:0]  c_count;

  vis_packetiser #(.ACCUM(8), .MBYTES(2), .HEADER(1), .SEQ_BITS(4)) u_c (
    .clock(clock), .reset(reset),
    .s_tvalid(c_s_tvalid), .s_tready(c_s_tready), .s_tlast(c_s_tlast),
    .s_revis(c_revis), .s_imvis(c_imvis),
    .m_tvalid(c_m_tvalid), .m_tready(c_m_tready), .m_tkeep(c_m_tkeep),
    .m_tlast(c_m_tlast), .m_tdata(c_m_tdata),
    .frame_count_o(c_count), .busy_o(c_busy)
  );

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [3:0]  pat;
    logic [95:0] exp;
    int          cnt;
  } vec_t;

  vec_t vecs[4];

  logic [31:0] wre[$];
  logic [31:0] wim[$];
  logic        wlast[$];
  int          wi;
  logic [7:0]  cap_d[$];
  logic        cap_l[$];
  int          first_cyc, last_cyc;
  logic [15:0] cq[$];
  logic        cl[$];
  logic [7:0]  model[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_a(input logic [3:0] pat, input int n_beats);
    int c;
    logic stalled;
    logic [7:0] prev;
    c = 0;
    stalled = 1'b0;
    prev = '0;
    first_cyc = -1;
    last_cyc = -1;
    cap_d.delete();
    cap_l.delete();
    while (cap_d.size() < n_beats && c < 2000) begin
      if (wi < wre.size()) begin
        a_s_tvalid = 1'b1;
        a_revis    = wre[wi];
        a_imvis    = wim[wi];
        a_s_tlast  = wlast[wi];
      end else begin
        a_s_tvalid = 1'b0;
        a_s_tlast  = 1'b0;
      end
      a_m_tready = pat[c[1:0]];
      @(negedge clock);
      if (stalled) check("stall_hold", 64'({a_m_tvalid, a_m_tdata}), 64'({1'b1, prev}));
      stalled = a_m_tvalid && !a_m_tready;
      prev = a_m_tdata;
      if (a_m_tvalid) check("tkeep", 64'(a_m_tkeep), 64'(1));
      if (a_m_tvalid && a_m_tready) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        cap_d.push_back(a_m_tdata);
        cap_l.push_back(a_m_tlast);
      end
      if (a_s_tvalid && a_s_tready) wi++;
      @(posedge clock);
      #1;
      c++;
    end
    if (cap_d.size() < n_beats) check("run_a_timeout", 64'(cap_d.size()), 64'(n_beats));
    a_s_tvalid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{re: 32'h11223344, im: 32'h55667788, pat: 4'b1111,
                exp: 96'h5A04_0000_8877_6655_4433_2211, cnt: 1};
    vecs[1] = '{re: 32'h11223344, im: 32'h55667788, pat: 4'b1001,
                exp: 96'h5A04_0100_8877_6655_4433_2211, cnt: 2};
    vecs[2] = '{re: 32'hDEADBEEF, im: 32'h01020304, pat: 4'b1011,
                exp: 96'h5A04_0200_0403_0201_EFBE_ADDE, cnt: 3};
    vecs[3] = '{re: 32'h00000000, im: 32'hFFFFFFFF, pat: 4'b0110,
                exp: 96'h5A04_0300_FFFF_FFFF_0000_0000, cnt: 4};

    reset = 1'b1;
    a_s_tvalid = 0; a_s_tlast = 0; a_revis = 0; a_imvis = 0; a_m_tready = 0;
    b_s_tvalid = 0; b_s_tlast = 0; b_revis = 0; b_imvis = 0; b_m_tready = 0;
    c_s_tvalid = 0; c_s_tlast = 0; c_revis = 0; c_imvis = 0; c_m_tready = 0;
    wi = 0;
    repeat (3) @(posedge clock);
    #1;
    a_s_tvalid = 1'b1;
    b_s_tvalid = 1'b1;
    @(negedge clock);
    check("rst_m_tvalid", 64'(a_m_tvalid), 64'(0));
    check("rst_m_tlast", 64'(a_m_tlast), 64'(0));
    check("rst_m_tdata", 64'(a_m_tdata), 64'(0));
    check("rst_busy", 64'(a_busy), 64'(0));
    check("rst_s_tready", 64'(a_s_tready), 64'(0));
    check("rst_b_s_tready", 64'(b_s_tready), 64'(0));
    check("rst_count", 64'(a_count), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    a_s_tvalid = 1'b0;
    b_s_tvalid = 1'b0;
    @(negedge clock);
    check("post_rst_s_tready", 64'(a_s_tready), 64'(0));
    check("post_rst_m_tvalid", 64'(a_m_tvalid), 64'(0));
    @(posedge clock);
    #1;

    // raw 4-byte beats, next word taken on the final handshake of the previous one
    b_s_tvalid = 1'b1; b_revis = 32'h11223344; b_imvis = 32'h55667788; b_s_tlast = 1'b1; b_m_tready = 1'b1;
    @(negedge clock);
    check("b_idle_ready", 64'(b_s_tready), 64'(1));
    @(posedge clock); #1;
    b_revis = 32'hAAAABBBB; b_imvis = 32'hCCCCDDDD;
    @(negedge clock);
    check("b_beat0", 64'({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata}), 64'({1'b1, 1'b0, 4'hF, 32'h55667788}));
    check("b_beat0_ready", 64'(b_s_tready), 64'(0));
    @(posedge clock); #1;
    @(negedge clock);
    check("b_beat1", 64'({b_m_tvalid, b_m_tlast, b_m_tdata}), 64'({1'b1, 1'b1, 32'h11223344}));
    check("b_beat1_ready", 64'(b_s_tready), 64'(1));
    @(posedge clock); #1;
    b_s_tvalid = 1'b0;
    @(negedge clock);
    check("b_w2_beat0", 64'({b_m_tvalid, b_m_tlast, b_m_tdata}), 64'({1'b1, 1'b0, 32'hCCCCDDDD}));
    check("b_count1", 64'(b_count), 64'(1));
    @(posedge clock); #1;
    @(negedge clock);
    check("b_w2_beat1", 64'({b_m_tvalid, b_m_tlast, b_m_tdata}), 64'({1'b1, 1'b1, 32'hAAAABBBB}));
    @(posedge clock); #1;
    @(negedge clock);
    check("b_idle", 64'({b_m_tvalid, b_busy}), 64'(0));
    check("b_count2", 64'(b_count), 64'(2));
    @(posedge clock); #1;

    // 17 single-word frames through the 4-bit sequence instance
    c_s_tvalid = 1'b1; c_revis = 8'h3C; c_imvis = 8'hC3; c_s_tlast = 1'b1; c_m_tready = 1'b1;
    for (int k = 0; k < 300 && cq.size() < 51; k++) begin
      @(negedge clock);
      if (c_m_tvalid && c_m_tready) begin
        cq.push_back(c_m_tdata);
        cl.push_back(c_m_tlast);
      end
      @(posedge clock); #1;
    end
    c_s_tvalid = 1'b0;
    check("c_beats", 64'(cq.size()), 64'(51));
    if (cq.size() >= 51) begin
      check("c_hdr0", 64'(cq[0]), 64'(16'h015A));
      check("c_seq0", 64'(cq[1]), 64'(16'h0000));
      check("c_word0", 64'({cl[0], cl[1], cl[2], cq[2]}), 64'({1'b0, 1'b0, 1'b1, 16'h3CC3}));
      check("c_seq15", 64'(cq[46]), 64'(16'h000F));
      check("c_seq16_wrapped", 64'(cq[49]), 64'(16'h0000));
    end
    @(negedge clock);
    check("c_count", 64'(c_count), 64'(1));
    @(posedge clock); #1;

    // single-word frames under different m_tready patterns
    foreach (vecs[r]) begin
      wre = '{vecs[r].re};
      wim = '{vecs[r].im};
      wlast = '{1'b1};
      wi = 0;
      run_a(vecs[r].pat, 12);
      for (int b = 0; b < 12 && b < cap_d.size(); b++) begin
        check($sformatf("v%0d_byte%0d", r, b), 64'(cap_d[b]), 64'(vecs[r].exp[95 - 8*b -: 8]));
        check($sformatf("v%0d_tlast%0d", r, b), 64'(cap_l[b]), 64'(b == 11));
      end
      @(negedge clock);
      check($sformatf("v%0d_count", r), 64'(a_count), 64'(vecs[r].cnt));
      check($sformatf("v%0d_idle", r), 64'({a_m_tvalid, a_busy}), 64'(0));
      @(posedge clock); #1;
    end

    // three back-to-back words in one frame
    wre = '{32'hA0A1A2A3, 32'hC0C1C2C3, 32'hE0E1E2E3};
    wim = '{32'hB0B1B2B3, 32'hD0D1D2D3, 32'hF0F1F2F3};
    wlast = '{1'b0, 1'b0, 1'b1};
    wi = 0;
    model = '{8'h5A, 8'h04, 8'h04, 8'h00};
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) model.push_back(wim[w][8*i +: 8]);
      for (int i = 0; i < 4; i++) model.push_back(wre[w][8*i +: 8]);
    end
    run_a(4'b1111, 28);
    for (int b = 0; b < 28 && b < cap_d.size(); b++) begin
      check($sformatf("f3_byte%0d", b), 64'(cap_d[b]), 64'(model[b]));
      check($sformatf("f3_tlast%0d", b), 64'(cap_l[b]), 64'(b == 27));
    end
    check("f3_no_bubble", 64'(last_cyc - first_cyc), 64'(27));
    @(negedge clock);
    check("f3_count", 64'(a_count), 64'(5));
    @(posedge clock); #1;

    // reset while beat 6 is on the bus
    wre = '{32'h11223344};
    wim = '{32'h55667788};
    wlast = '{1'b1};
    wi = 0;
    run_a(4'b1111, 5);
    check("mid_beat6", 64'({a_m_tvalid, a_m_tdata}), 64'({1'b1, 8'h77}));
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_valid", 64'({a_m_tvalid, a_m_tlast, a_busy}), 64'(0));
    check("mid_rst_count", 64'(a_count), 64'(0));
    wi = 0;
    run_a(4'b1111, 12);
    for (int b = 0; b < 4 && b < cap_d.size(); b++)
      check($sformatf("after_rst_hdr%0d", b), 64'(cap_d[b]), 64'(vecs[0].exp[95 - 8*b -: 8]));
    if (cap_l.size() == 12) check("after_rst_tlast", 64'(cap_l[11]), 64'(1));
    @(negedge clock);
    check("after_rst_count", 64'(a_count), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
